// File: rtl/redundant_canon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : redundant_canon                                               |
// | Purpose  : Limb-serial carry propagation and bounded trial subtraction   |
// |            of the modulus, turning a redundant operand into [0, M).      |
// | Options  : REDUNDANT_CANON_ERR_EN adds the err output (ovf | sat).       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module redundant_canon #(
   parameter int NUM_ELEMENTS = 17,
   parameter int BIT_LEN      = 17,
   parameter int WORD_LEN     = 16,
   parameter int MAX_SUB      = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  A,
   input  logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0] M,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0] Y
`ifdef REDUNDANT_CANON_ERR_EN
   ,
   output logic                                  err
`endif
);

   localparam int c_cw = BIT_LEN - WORD_LEN + 1;
   localparam int c_lw = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
   localparam int c_pw = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;

   localparam logic [c_lw-1:0] c_last_limb = c_lw'(NUM_ELEMENTS - 1);
   localparam logic [c_pw-1:0] c_max_sub   = c_pw'(MAX_SUB);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_carry = 2'd1;
   localparam logic [1:0] c_sub   = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   logic [1:0]                                r_state;
   logic [1:0]                                w_next_state;
   logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]      r_a;
   logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]     r_m;
   logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]     r_x;
   logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]     r_d;
   logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]     w_d_final;
   logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]     r_y;
   logic [c_cw-1:0]                           r_carry;
   logic                                      r_borrow;
   logic [c_lw-1:0]                           r_limb;
   logic [c_pw-1:0]                           r_commits;
   logic                                      r_ovf;
   logic                                      r_sat;
   logic                                      r_out_valid;

   logic [BIT_LEN:0]                          w_sum;
   logic [c_cw-1:0]                           w_carry_next;
   logic [WORD_LEN:0]                         w_diff;
   logic                                      w_borrow_next;
   logic                                      w_last;
   logic                                      w_accept;
   logic                                      w_pass_end;
   logic                                      w_commit;
   logic                                      w_sat_hit;
   logic                                      w_ovf_hit;
   logic                                      w_load_out;
   logic                                      w_release;

   // Per-limb arithmetic shared by the carry walk and the subtraction pass
   always_comb begin
      w_sum         = {1'b0, r_a[r_limb]} + {{(BIT_LEN + 1 - c_cw){1'b0}}, r_carry};
      w_carry_next  = w_sum[BIT_LEN:WORD_LEN];
      w_diff        = {1'b0, r_x[r_limb]} - {1'b0, r_m[r_limb]}
                      - {{WORD_LEN{1'b0}}, r_borrow};
      w_borrow_next = w_diff[WORD_LEN];
      w_last        = (r_limb == c_last_limb);
      w_d_final     = r_d;
      w_d_final[NUM_ELEMENTS-1] = w_diff[WORD_LEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         c_idle:  if (in_valid) w_next_state = c_carry;
         c_carry: if (w_last) w_next_state = (w_carry_next != '0) ? c_done : c_sub;
         c_sub:   if (w_last && (w_borrow_next || (r_commits == c_max_sub)))
                     w_next_state = c_done;
         c_done:  if (r_out_valid && out_ready) w_next_state = c_idle;
         default: w_next_state = c_idle;
      endcase
   end

   always_comb begin
      in_ready   = (r_state == c_idle);
      w_accept   = in_ready && in_valid;
      w_pass_end = (r_state == c_sub) && w_last;
      w_commit   = w_pass_end && !w_borrow_next && (r_commits < c_max_sub);
      w_sat_hit  = w_pass_end && !w_borrow_next && (r_commits == c_max_sub);
      w_ovf_hit  = (r_state == c_carry) && w_last && (w_carry_next != '0);
      w_load_out = (r_state == c_done) && !r_out_valid;
      w_release  = (r_state == c_done) && r_out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_m         <= '0;
         r_x         <= '0;
         r_d         <= '0;
         r_y         <= '0;
         r_carry     <= '0;
         r_borrow    <= 1'b0;
         r_limb      <= '0;
         r_commits   <= '0;
         r_ovf       <= 1'b0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a       <= A;
            r_m       <= M;
            r_carry   <= '0;
            r_borrow  <= 1'b0;
            r_limb    <= '0;
            r_commits <= '0;
            r_ovf     <= 1'b0;
            r_sat     <= 1'b0;
         end
         if (r_state == c_carry) begin
            r_x[r_limb] <= w_sum[WORD_LEN-1:0];
            r_carry     <= w_carry_next;
            r_limb      <= w_last ? '0 : r_limb + c_lw'(1);
            if (w_ovf_hit) r_ovf <= 1'b1;
         end
         if (r_state == c_sub) begin
            r_d[r_limb] <= w_diff[WORD_LEN-1:0];
            r_borrow    <= w_last ? 1'b0 : w_borrow_next;
            r_limb      <= w_last ? '0 : r_limb + c_lw'(1);
            // Only a whole non-negative difference replaces X
            if (w_commit) begin
               r_x       <= w_d_final;
               r_commits <= r_commits + c_pw'(1);
            end
            if (w_sat_hit) r_sat <= 1'b1;
         end
         if (w_load_out) begin
            r_y         <= r_x;
            r_out_valid <= 1'b1;
         end
         if (w_release) r_out_valid <= 1'b0;
      end
   end

`ifdef REDUNDANT_CANON_ERR_EN
   logic r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_load_out) begin
         r_err <= r_ovf | r_sat;
      end
   end

   assign err = r_err;
`else
   // ovf/sat are tracked regardless; this build simply has no port for them
`endif

   assign out_valid = r_out_valid;
   assign Y         = r_y;

endmodule
`default_nettype wire
